// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - opcode/funct encodings, one-hot op indices and decoded-entry type
// Shared by the ID stage and its helpers:
//   OPC_*   6-bit primary opcodes (instr[31:26])
//   FUNCT_* 6-bit R-type function codes (instr[5:0])
//   OP_*    bit positions in the one-hot op vector, NUM_OPS wide
//   dec_t   fields produced by the decoder and held in the pipeline register
package mips_defs;

   localparam int NUM_OPS = 16;

   localparam int OP_ADD  = 0;
   localparam int OP_SUB  = 1;
   localparam int OP_SLL  = 2;
   localparam int OP_SLLV = 3;
   localparam int OP_SLT  = 4;
   localparam int OP_JR   = 5;
   localparam int OP_MULT = 6;
   localparam int OP_DIV  = 7;
   localparam int OP_MFHI = 8;
   localparam int OP_MFLO = 9;
   localparam int OP_ORI  = 10;
   localparam int OP_LW   = 11;
   localparam int OP_SW   = 12;
   localparam int OP_BEQ  = 13;
   localparam int OP_LUI  = 14;
   localparam int OP_JAL  = 15;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ORI   = 6'b001101;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_LUI   = 6'b001111;
   localparam logic [5:0] OPC_JAL   = 6'b000011;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SLLV = 6'b000100;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;
   localparam logic [5:0] FUNCT_JR   = 6'b001000;
   localparam logic [5:0] FUNCT_MULT = 6'b011000;
   localparam logic [5:0] FUNCT_DIV  = 6'b011010;
   localparam logic [5:0] FUNCT_MFHI = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO = 6'b010010;

   typedef struct packed {
      logic [NUM_OPS-1:0] op;
      logic               illegal;
      logic               md_cls;   // op needs the MD unit to be idle before issue
      logic [4:0]         rs;
      logic [4:0]         rt;
      logic [4:0]         rd;
      logic [4:0]         shamt;
      logic [31:0]        imm;
      logic [25:0]        jidx;
   } dec_t;

endpackage

// File: rtl/md_busy_counter.sv
// rtl/md_busy_counter.sv - mult/div busy countdown with load priority over decrement
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load_i         load load_val_i this cycle (wins over the decrement)
//   load_val_i     cycles the MD unit stays busy
//   md_busy_o      counter is non-zero
module md_busy_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             md_busy_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign md_busy_o = (cnt_q != '0);

endmodule

// File: rtl/id_stage_decoder.sv
// rtl/id_stage_decoder.sv - registered MIPS instruction decode stage with MD busy interlock
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   kill held entry and any entry accepted this cycle
//   in_valid/in_ready       upstream handshake; in_instr, in_pc payload
//   out_valid/out_ready     downstream handshake
//   out_op, out_illegal     one-hot op vector, unrecognised-encoding flag
//   out_rs/rt/rd/shamt      raw register / shift fields
//   out_imm, out_jidx       extended immediate, jump index
//   out_pc                  PC of the held entry
//   md_busy                 MD unit still working on an issued mult/div
module id_stage_decoder
   import mips_defs::*;
#(
   parameter int PC_W       = 32,
   parameter int MD_MUL_LAT = 5,
   parameter int MD_DIV_LAT = 10,
   parameter int EN_MD      = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OPS-1:0] out_op,
   output logic               out_illegal,
   output logic [4:0]         out_rs,
   output logic [4:0]         out_rt,
   output logic [4:0]         out_rd,
   output logic [4:0]         out_shamt,
   output logic [31:0]        out_imm,
   output logic [25:0]        out_jidx,
   output logic [PC_W-1:0]    out_pc,
   output logic               md_busy
);

   localparam logic [3:0] MUL_LD = 4'(MD_MUL_LAT);
   localparam logic [3:0] DIV_LD = 4'(MD_DIV_LAT);

   function automatic dec_t decode(input logic [31:0] instr);
      dec_t d;
      d       = '0;
      d.rs    = instr[25:21];
      d.rt    = instr[20:16];
      d.rd    = instr[15:11];
      d.shamt = instr[10:6];
      d.jidx  = instr[25:0];
      d.imm   = {{16{instr[15]}}, instr[15:0]};
      case (instr[31:26])
         OPC_RTYPE: begin
            case (instr[5:0])
               FUNCT_ADD:  d.op[OP_ADD]  = 1'b1;
               FUNCT_SUB:  d.op[OP_SUB]  = 1'b1;
               FUNCT_SLL:  d.op[OP_SLL]  = 1'b1;
               FUNCT_SLLV: d.op[OP_SLLV] = 1'b1;
               FUNCT_SLT:  d.op[OP_SLT]  = 1'b1;
               FUNCT_JR:   d.op[OP_JR]   = 1'b1;
               FUNCT_MULT: d.op[OP_MULT] = (EN_MD != 0);
               FUNCT_DIV:  d.op[OP_DIV]  = (EN_MD != 0);
               FUNCT_MFHI: d.op[OP_MFHI] = (EN_MD != 0);
               FUNCT_MFLO: d.op[OP_MFLO] = (EN_MD != 0);
               default:    ;
            endcase
         end
         OPC_ORI: begin
            d.op[OP_ORI] = 1'b1;
            d.imm        = {16'h0000, instr[15:0]};
         end
         OPC_LW:  d.op[OP_LW]  = 1'b1;
         OPC_SW:  d.op[OP_SW]  = 1'b1;
         OPC_BEQ: d.op[OP_BEQ] = 1'b1;
         OPC_LUI: begin
            d.op[OP_LUI] = 1'b1;
            d.imm        = {instr[15:0], 16'h0000};
         end
         OPC_JAL: d.op[OP_JAL] = 1'b1;
         default: ;
      endcase
      d.illegal = (d.op == '0);
      d.md_cls  = d.op[OP_MULT] | d.op[OP_DIV] | d.op[OP_MFHI] | d.op[OP_MFLO];
      return d;
   endfunction

   logic            vld_q, vld_d;
   dec_t            dec_q, dec_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            fire, accept, md_load;
   logic [3:0]      md_load_val;

   // An MD-class entry waits in the register until the unit drains; the
   // register itself stays full so in_ready drops and the fields hold still.
   assign out_valid = vld_q & ~(dec_q.md_cls & md_busy);
   assign fire      = out_valid & out_ready;
   assign in_ready  = ~vld_q | fire;
   assign accept    = in_valid & in_ready;

   always_comb begin
      vld_d = vld_q;
      dec_d = dec_q;
      pc_d  = pc_q;
      if (flush) begin
         vld_d = 1'b0;
      end else if (accept) begin
         vld_d = 1'b1;
         dec_d = decode(in_instr);
         pc_d  = in_pc;
      end else if (fire) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= 1'b0;
         dec_q <= '0;
         pc_q  <= '0;
      end else begin
         vld_q <= vld_d;
         dec_q <= dec_d;
         pc_q  <= pc_d;
      end
   end

   // A flush never cancels an issue that fires in the same cycle, so the
   // counter load depends on fire alone.
   assign md_load     = fire & (dec_q.op[OP_MULT] | dec_q.op[OP_DIV]);
   assign md_load_val = dec_q.op[OP_MULT] ? MUL_LD : DIV_LD;

   md_busy_counter #(.CNT_W(4)) u_md_busy_counter (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (md_load),
      .load_val_i (md_load_val),
      .md_busy_o  (md_busy)
   );

   assign out_op      = dec_q.op;
   assign out_illegal = dec_q.illegal;
   assign out_rs      = dec_q.rs;
   assign out_rt      = dec_q.rt;
   assign out_rd      = dec_q.rd;
   assign out_shamt   = dec_q.shamt;
   assign out_imm     = dec_q.imm;
   assign out_jidx    = dec_q.jidx;
   assign out_pc      = pc_q;

endmodule
